// File: rtl/updn_ctr_seq.sv
// Command sequencer driving an external up/down counter: optional preload, then a
// prescaled burst of cen pulses, with abort and wrap detection from the counter feedback.
module updn_ctr_seq #(
   parameter int unsigned WIDTH  = 3,
   parameter int unsigned STEP_W = 8,
   parameter int unsigned RATE_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_dir,
   input  logic              cmd_load,
   input  logic [WIDTH-1:0]  cmd_data,
   input  logic [STEP_W-1:0] cmd_steps,
   input  logic [RATE_W-1:0] rate,
   input  logic              abort,
   input  logic [WIDTH-1:0]  count_in,
   output logic              up_dn,
   output logic              load,
   output logic [WIDTH-1:0]  data,
   output logic              cen,
   output logic              busy,
   output logic              done,
   output logic              aborted,
   output logic              wrap_evt
);

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StLoad = 2'd1;
   localparam logic [1:0] StRun  = 2'd2;
   localparam logic [1:0] StDone = 2'd3;

   logic [1:0]        state_q, state_d;
   logic [STEP_W-1:0] rem_q, rem_d;
   logic [RATE_W-1:0] psc_q, psc_d;
   logic [RATE_W-1:0] rate_q, rate_d;
   logic [WIDTH-1:0]  data_q, data_d;
   logic              dir_q, dir_d;
   logic              cen_q, cen_d;
   logic              wrap_q, wrap_d;
   logic              aborted_q, aborted_d;
   logic              wrap_hit;

   // The step about to be issued moves the counter past its end in the latched direction.
   assign wrap_hit = dir_q ? (count_in == {WIDTH{1'b1}}) : (count_in == '0);

   always_comb begin
      state_d   = state_q;
      rem_d     = rem_q;
      psc_d     = psc_q;
      rate_d    = rate_q;
      data_d    = data_q;
      dir_d     = dir_q;
      cen_d     = 1'b0;
      wrap_d    = 1'b0;
      aborted_d = 1'b0;
      case (state_q)
         StIdle: begin
            if (cmd_valid) begin
               dir_d  = cmd_dir;
               rem_d  = cmd_steps;
               rate_d = rate;
               psc_d  = '0;
               if (cmd_load) begin
                  data_d  = cmd_data;
                  state_d = StLoad;
               end else begin
                  state_d = (cmd_steps != '0) ? StRun : StDone;
               end
            end
         end
         StLoad: begin
            psc_d = '0;
            if (abort) begin
               state_d   = StDone;
               aborted_d = 1'b1;
            end else begin
               state_d = (rem_q != '0) ? StRun : StDone;
            end
         end
         StRun: begin
            if (abort) begin
               state_d   = StDone;
               aborted_d = 1'b1;
            end else if (psc_q == rate_q) begin
               psc_d  = '0;
               cen_d  = 1'b1;
               wrap_d = wrap_hit;
               if (rem_q != '0) rem_d = rem_q - 1'b1;
               // Final pulse lands together with done.
               if (rem_q <= STEP_W'(1)) state_d = StDone;
            end else begin
               psc_d = psc_q + 1'b1;
            end
         end
         StDone: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= StIdle;
         rem_q     <= '0;
         psc_q     <= '0;
         rate_q    <= '0;
         data_q    <= '0;
         dir_q     <= 1'b0;
         cen_q     <= 1'b0;
         wrap_q    <= 1'b0;
         aborted_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         rem_q     <= rem_d;
         psc_q     <= psc_d;
         rate_q    <= rate_d;
         data_q    <= data_d;
         dir_q     <= dir_d;
         cen_q     <= cen_d;
         wrap_q    <= wrap_d;
         aborted_q <= aborted_d;
      end
   end

   assign cmd_ready = (state_q == StIdle);
   assign busy      = (state_q != StIdle);
   assign load      = (state_q == StLoad);
   assign done      = (state_q == StDone);
   assign up_dn     = dir_q;
   assign data      = data_q;
   assign cen       = cen_q;
   assign wrap_evt  = wrap_q;
   assign aborted   = aborted_q;

endmodule

// File: tb/tb_updn_ctr_seq.sv
// Directed bench for updn_ctr_seq: cycle-by-cycle expectations for load, stepping,
// prescaling, wrap, abort and mid-command reset.
module tb_updn_ctr_seq;

   logic       clk = 1'b0;
   logic       reset;
   logic       cmd_valid, cmd_ready, cmd_dir, cmd_load;
   logic [2:0] cmd_data;
   logic [7:0] cmd_steps, rate;
   logic       abort;
   logic [2:0] count_in;
   logic       up_dn, load, cen, busy, done, aborted, wrap_evt;
   logic [2:0] data;

   int total = 0;
   int bad   = 0;

   updn_ctr_seq dut (
      .clk       (clk),
      .reset     (reset),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_dir   (cmd_dir),
      .cmd_load  (cmd_load),
      .cmd_data  (cmd_data),
      .cmd_steps (cmd_steps),
      .rate      (rate),
      .abort     (abort),
      .count_in  (count_in),
      .up_dn     (up_dn),
      .load      (load),
      .data      (data),
      .cen       (cen),
      .busy      (busy),
      .done      (done),
      .aborted   (aborted),
      .wrap_evt  (wrap_evt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic d, input logic ld, input logic [2:0] dat,
                        input logic [7:0] st, input logic [7:0] rt);
      cmd_valid = 1'b1;
      cmd_dir   = d;
      cmd_load  = ld;
      cmd_data  = dat;
      cmd_steps = st;
      rate      = rt;
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic chk_reset_outs(input string tag);
      chk({tag, "_ready"}, cmd_ready, 1);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_cen"}, cen, 0);
      chk({tag, "_load"}, load, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_abrt"}, aborted, 0);
      chk({tag, "_wrap"}, wrap_evt, 0);
      chk({tag, "_updn"}, up_dn, 0);
      chk({tag, "_data"}, data, 0);
   endtask

   initial begin
      reset = 1'b0; cmd_valid = 1'b0; cmd_dir = 1'b0; cmd_load = 1'b0;
      cmd_data = '0; cmd_steps = '0; rate = '0; abort = 1'b0; count_in = 3'd3;
      tick(); tick();
      chk_reset_outs("rst");
      reset = 1'b1;
      tick();
      chk("idle_ready", cmd_ready, 1);

      // Preload 5, three steps back to back.
      issue(1'b1, 1'b1, 3'd5, 8'd3, 8'd0);
      chk("t1_load", load, 1);
      chk("t1_data", data, 5);
      chk("t1_updn", up_dn, 1);
      chk("t1_busy", busy, 1);
      chk("t1_ready", cmd_ready, 0);
      chk("t1_cen0", cen, 0);
      tick();
      chk("t1_load_off", load, 0);
      chk("t1_run_cen0", cen, 0);
      for (int k = 1; k <= 3; k++) begin
         tick();
         chk($sformatf("t1_cen%0d", k), cen, 1);
         chk($sformatf("t1_done%0d", k), done, (k == 3) ? 1 : 0);
         chk($sformatf("t1_wrap%0d", k), wrap_evt, 0);
      end
      chk("t1_abrt", aborted, 0);
      tick();
      chk("t1_cen_end", cen, 0);
      chk("t1_idle", cmd_ready, 1);
      chk("t1_data_hold", data, 5);

      // Down, rate 3, two steps; counter at 0 so every step wraps.
      count_in = 3'd0;
      issue(1'b0, 1'b0, 3'd1, 8'd2, 8'd3);
      chk("t2_updn", up_dn, 0);
      chk("t2_load", load, 0);
      chk("t2_data_hold", data, 5);
      for (int k = 1; k <= 8; k++) begin
         tick();
         chk($sformatf("t2_cen%0d", k), cen, (k == 4 || k == 8) ? 1 : 0);
         chk($sformatf("t2_wrap%0d", k), wrap_evt, (k == 4 || k == 8) ? 1 : 0);
         chk($sformatf("t2_done%0d", k), done, (k == 8) ? 1 : 0);
      end
      tick();
      chk("t2_busy_end", busy, 0);

      // Zero steps goes straight to DONE.
      issue(1'b1, 1'b0, 3'd0, 8'd0, 8'd5);
      chk("t3_done", done, 1);
      chk("t3_cen", cen, 0);
      chk("t3_busy", busy, 1);
      tick();
      chk("t3_done_off", done, 0);
      chk("t3_cen_off", cen, 0);
      chk("t3_idle", cmd_ready, 1);

      // Up wrap at 7, then no wrap at 6.
      count_in = 3'd7;
      issue(1'b1, 1'b0, 3'd0, 8'd2, 8'd0);
      tick();
      chk("t4_cen1", cen, 1);
      chk("t4_wrap1", wrap_evt, 1);
      count_in = 3'd6;
      tick();
      chk("t4_cen2", cen, 1);
      chk("t4_wrap2", wrap_evt, 0);
      chk("t4_done", done, 1);
      tick();

      // Abort after second pulse of a ten-step command.
      count_in = 3'd2;
      issue(1'b1, 1'b0, 3'd0, 8'd10, 8'd1);
      for (int k = 1; k <= 4; k++) begin
         tick();
         chk($sformatf("t5_cen%0d", k), cen, (k == 2 || k == 4) ? 1 : 0);
      end
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("t5_done", done, 1);
      chk("t5_abrt", aborted, 1);
      chk("t5_cen", cen, 0);
      tick();
      chk("t5_ready", cmd_ready, 1);
      chk("t5_abrt_off", aborted, 0);
      chk("t5_cen_after", cen, 0);

      // Abort together with a command in IDLE is ignored.
      abort = 1'b1;
      issue(1'b0, 1'b0, 3'd0, 8'd1, 8'd0);
      abort = 1'b0;
      chk("t6_busy", busy, 1);
      chk("t6_done0", done, 0);
      tick();
      chk("t6_cen", cen, 1);
      chk("t6_done", done, 1);
      chk("t6_abrt", aborted, 0);
      tick();

      // Reset mid-run with four steps remaining.
      issue(1'b1, 1'b1, 3'd2, 8'd6, 8'd0);
      tick(); tick(); tick();
      chk("t7_cen_pre", cen, 1);
      reset = 1'b0; abort = 1'b1; cmd_valid = 1'b1; cmd_steps = 8'd0;
      tick();
      chk_reset_outs("t7_rst");
      cmd_valid = 1'b0; abort = 1'b0;
      tick();
      chk("t7_no_done", done, 0);
      reset = 1'b1;
      issue(1'b0, 1'b0, 3'd0, 8'd1, 8'd0);
      chk("t7_new_busy", busy, 1);
      tick();
      chk("t7_new_cen", cen, 1);
      chk("t7_new_done", done, 1);
      tick();
      chk("t7_new_idle", cmd_ready, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/updn_ctr_seq.md
UPDN_CTR_SEQ -- requirements
Module: updn_ctr_seq

Interface
REQ-001 Parameter: WIDTH, default 3, counter data width; matches the downstream up/down counter.
REQ-002 Parameter: STEP_W, default 8, width of step-count field.
REQ-003 Parameter: RATE_W, default 8, width of prescaler rate field.
REQ-004 clk  input  1  rising-edge clock shared with downstream counter.
REQ-005 reset  input  1  reset, synchronous, active-low.
REQ-006 cmd_valid  input  1  command present.
REQ-007 cmd_ready  output  1  sequencer can accept a command.
REQ-008 cmd_dir  input  1  1 = count up, 0 = count down.
REQ-009 cmd_load  input  1  preload counter with cmd_data before stepping.
REQ-010 cmd_data  input  WIDTH  preload value.
REQ-011 cmd_steps  input  STEP_W  number of cen pulses to issue (0 allowed).
REQ-012 rate  input  RATE_W  pulse spacing; cen period = rate+1 cycles; sampled at command acceptance.
REQ-013 abort  input  1  terminate current command.
REQ-014 count_in  input  WIDTH  counter value fed back from the counter.
REQ-015 up_dn  output  1  direction to counter.
REQ-016 load  output  1  counter load strobe.
REQ-017 data  output  WIDTH  counter load value.
REQ-018 cen  output  1  counter enable pulse.
REQ-019 busy  output  1  command in progress (state != IDLE).
REQ-020 done  output  1  one-cycle completion pulse.
REQ-021 aborted  output  1  valid with done; 1 = command ended by abort.
REQ-022 wrap_evt  output  1  one-cycle pulse: current cen step will wrap the counter.

Function
REQ-023 FSM states IDLE, LOAD, RUN, DONE; all outputs registered or decoded from registered state only.
REQ-024 cmd_ready SHALL be 1 only in IDLE; acceptance = cmd_valid & cmd_ready at a rising edge.
REQ-025 On acceptance: latch dir, data, steps, rate; next state LOAD if cmd_load, else RUN if steps != 0, else DONE.
REQ-026 LOAD lasts exactly one cycle: load=1, data=latched cmd_data; next RUN if steps != 0, else DONE.
REQ-027 up_dn SHALL hold latched dir from acceptance until return to IDLE; load=0 and data holds last value outside LOAD.
REQ-028 RUN: prescaler cleared on entry; each cycle, if prescaler == rate then clear it, assert cen next cycle, decrement remaining; else increment prescaler, cen=0 next cycle.
REQ-029 First cen pulse occurs rate+1 cycles after RUN entry; rate=0 gives cen high every RUN cycle.
REQ-030 When remaining reaches 0, next state DONE; the final cen pulse and done SHALL be high in the same cycle.
REQ-031 Exactly cmd_steps cen pulses per uninterrupted command; no cen outside RUN except the final one coincident with DONE.
REQ-032 DONE lasts exactly one cycle: done=1; then IDLE.
REQ-033 wrap_evt SHALL be high in the same cycle as cen when, at the issuing edge, (dir=1 and count_in = 2^WIDTH-1) or (dir=0 and count_in = 0).
REQ-034 abort high in LOAD or RUN: next state DONE with aborted=1, cen and load 0 from that edge; any pulse in progress is dropped.
REQ-035 abort in IDLE or DONE SHALL be ignored; abort and cmd_valid together in IDLE: abort ignored, command accepted.
REQ-036 Remaining/prescaler arithmetic SHALL be unsigned, no wrap; remaining never decremented below 0.

Reset
REQ-037 reset=0 at a rising edge: state IDLE, cmd_ready=1, busy=0, cen=0, load=0, done=0, aborted=0, wrap_evt=0, up_dn=0, data=0, prescaler=0, remaining=0.
REQ-038 Reset mid-command SHALL discard the command with no done pulse; reset overrides abort and cmd_valid.

Verification
REQ-039 Accept dir=1, load=1, data=5, steps=3, rate=0 -> load=1 one cycle, data=5; cen high 3 consecutive cycles; done with third cen; aborted=0.
REQ-040 Accept dir=0, load=0, steps=2, rate=3 -> cen pulses 4 and 8 cycles after RUN entry; done coincides with second; busy low next cycle.
REQ-041 Accept steps=0, load=0 -> DONE next cycle, done=1 one cycle, zero cen pulses.
REQ-042 dir=1, count_in=7, WIDTH=3, cen issuing -> wrap_evt=1 same cycle; dir=0, count_in=0 -> wrap_evt=1.
REQ-043 steps=10, rate=1, abort after 2nd cen -> no further cen, done=1 and aborted=1 next cycle, cmd_ready=1 after.
REQ-044 Reset asserted during RUN with remaining=4 -> all outputs at REQ-037 values, no done, new command accepted after reset release.
